// File: rtl/agc_sequencer.sv
// rtl/agc_sequencer.sv - per-PRI AGC sequencer: settle, measure, step the HGA+PGA gain index
// Optional feature macro AGC_HYSTERESIS_EN: a step needs two consecutive same-direction out-of-window EVALs.
module agc_sequencer #(
  parameter int                 PGA_W          = 3,
  parameter int                 POWER_W        = 32,
  parameter int                 SETTLE_CYCLES  = 1000,
  parameter int                 PRI_CYCLES     = 100000,
  parameter int                 TIMEOUT_CYCLES = 4096,
  parameter logic [POWER_W-1:0] HI_THRESH      = POWER_W'(2**24),
  parameter logic [POWER_W-1:0] LO_THRESH      = POWER_W'(2**16),
  parameter logic [PGA_W:0]     GAIN_INIT      = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [POWER_W-1:0] power_i,
  input  logic               valid_i,
  output logic               dc_block_en_o,
  output logic               goertzel_start_o,
  output logic               hga_en_o,
  output logic [PGA_W-1:0]   pga_gain_o,
  output logic               timeout_o,
  output logic               locked_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(PRI_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, EVAL, HOLD} state_t;

  state_t             state_q;
  logic [SW-1:0]      settle_cnt_q;
  logic [TW-1:0]      to_cnt_q;
  logic [PW-1:0]      pri_cnt_q;
  logic [PGA_W:0]     gain_idx_q;
  logic [POWER_W-1:0] power_q;
  logic               dc_block_en_q;
  logic               goertzel_start_q;
  logic               timeout_q;
  logic               locked_q;

  logic pri_wrap, to_expire, too_hi, too_lo, step_up, step_dn;

  assign pri_wrap  = (pri_cnt_q == PW'(PRI_CYCLES - 1));
  assign to_expire = (state_q == WAIT) && !valid_i && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign too_hi    = (power_q > HI_THRESH);
  assign too_lo    = (power_q < LO_THRESH);

`ifdef AGC_HYSTERESIS_EN
  // {pending, pending direction is up}: first out-of-window EVAL arms, second same-direction one steps
  logic [1:0] hist_q;

  assign step_up = too_lo && (hist_q == 2'b11);
  assign step_dn = too_hi && (hist_q == 2'b10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
    end else if (!en_i || to_expire) begin
      hist_q <= '0;
    end else if (state_q == EVAL) begin
      if (step_up || step_dn || !(too_hi || too_lo)) hist_q <= '0;
      else                                           hist_q <= {1'b1, too_lo};
    end
  end
`else
  assign step_up = too_lo;
  assign step_dn = too_hi;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      settle_cnt_q     <= '0;
      to_cnt_q         <= '0;
      pri_cnt_q        <= '0;
      gain_idx_q       <= GAIN_INIT;
      power_q          <= '0;
      dc_block_en_q    <= 1'b0;
      goertzel_start_q <= 1'b0;
      timeout_q        <= 1'b0;
      locked_q         <= 1'b0;
    end else begin
      goertzel_start_q <= 1'b0;
      timeout_q        <= 1'b0;
      if (state_q != IDLE) pri_cnt_q <= pri_wrap ? '0 : pri_cnt_q + 1'b1;

      if (!en_i) begin
        // gain is deliberately kept so the amplifier does not jump while disabled
        state_q       <= IDLE;
        dc_block_en_q <= 1'b0;
        locked_q      <= 1'b0;
        pri_cnt_q     <= '0;
        settle_cnt_q  <= '0;
        to_cnt_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            gain_idx_q    <= GAIN_INIT;
            pri_cnt_q     <= '0;
            settle_cnt_q  <= '0;
            dc_block_en_q <= 1'b1;
            state_q       <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
              settle_cnt_q <= '0;
              state_q      <= START;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
          START: begin
            goertzel_start_q <= 1'b1;
            to_cnt_q         <= '0;
            state_q          <= WAIT;
          end
          WAIT: begin
            if (valid_i) begin
              power_q <= power_i;
              state_q <= EVAL;
            end else if (to_expire) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              state_q   <= HOLD;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          EVAL: begin
            locked_q <= !(too_hi || too_lo);
            if (step_up && (gain_idx_q != '1))      gain_idx_q <= gain_idx_q + 1'b1;
            else if (step_dn && (gain_idx_q != '0)) gain_idx_q <= gain_idx_q - 1'b1;
            state_q <= HOLD;
          end
          HOLD: begin
            if (pri_wrap) state_q <= SETTLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dc_block_en_o    = dc_block_en_q;
  assign goertzel_start_o = goertzel_start_q;
  assign timeout_o        = timeout_q;
  assign locked_o         = locked_q;
  assign hga_en_o         = gain_idx_q[PGA_W];
  assign pga_gain_o       = gain_idx_q[PGA_W-1:0];

endmodule

// File: tb/tb_agc_sequencer.sv
// tb/tb_agc_sequencer.sv - randomized PRI-level bench for agc_sequencer against a timeline/gain model
module tb_agc_sequencer;
  localparam int PGA_W = 3;
  localparam int PRI   = 64;
  localparam int GMAX  = 2**(PGA_W+1) - 1;
  localparam logic [31:0] HI = 32'd1000;
  localparam logic [31:0] LO = 32'd100;

  logic clk = 1'b0, rst = 1'b0, en_i = 1'b0, valid_i = 1'b0;
  logic [31:0] power_i = '0;
  logic dc_block_en_o, goertzel_start_o, hga_en_o, timeout_o, locked_o;
  logic [PGA_W-1:0] pga_gain_o;

  agc_sequencer #(
    .PGA_W(PGA_W), .POWER_W(32), .SETTLE_CYCLES(4), .PRI_CYCLES(PRI),
    .TIMEOUT_CYCLES(8), .HI_THRESH(HI), .LO_THRESH(LO), .GAIN_INIT(4'd0)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .power_i(power_i), .valid_i(valid_i),
    .dc_block_en_o(dc_block_en_o), .goertzel_start_o(goertzel_start_o),
    .hga_en_o(hga_en_o), .pga_gain_o(pga_gain_o), .timeout_o(timeout_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_gain = 0;
  int m_pend = 0;
  int m_locked = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_gain(input int g);
    return (g < 0) ? 0 : (g > GMAX) ? GMAX : g;
  endfunction

  function automatic void model_eval(input logic [31:0] pw);
    int dir;
    dir = (pw > HI) ? -1 : (pw < LO) ? 1 : 0;
    if (dir == 0) begin
      m_locked = 1;
      m_pend   = 0;
    end else begin
      m_locked = 0;
`ifdef AGC_HYSTERESIS_EN
      if (m_pend == dir) begin
        m_gain = clamp_gain(m_gain + dir);
        m_pend = 0;
      end else begin
        m_pend = dir;
      end
`else
      m_gain = clamp_gain(m_gain + dir);
`endif
    end
  endfunction

  task automatic check_pins(input string tag);
    check({tag, "_gain"}, 32'({hga_en_o, pga_gain_o}), 32'(m_gain));
    check({tag, "_locked"}, 32'(locked_o), 32'(m_locked));
  endtask

  // One PRI starting at its first SETTLE cycle: start pulse at offset 5, WAIT from 5,
  // valid at 5+d, gain/locked visible at 7+d, timeout at 13 when no valid is given.
  task automatic run_pri(input bit give_valid, input int d, input logic [31:0] pw, input bit stray);
    for (int o = 0; o < PRI; o++) begin
      if (give_valid && o == 7 + d) model_eval(pw);
      if (!give_valid && o == 13) begin
        m_locked = 0;
        m_pend   = 0;
      end
      check("start_pulse", 32'(goertzel_start_o), (o == 5) ? 1 : 0);
      check("timeout", 32'(timeout_o), (!give_valid && o == 13) ? 1 : 0);
      check("dc_en", 32'(dc_block_en_o), 1);
      check_pins("pri");
      valid_i = (give_valid && o == 5 + d) || (stray && o == 30);
      power_i = (give_valid && o == 5 + d) ? pw : valid_i ? 32'd50 : $urandom;
      tick;
    end
    valid_i = 1'b0;
  endtask

  task automatic rand_pri;
    logic [31:0] table_pw [9];
    int k;
    table_pw = '{32'd0, 32'd50, 32'd99, 32'd100, 32'd500, 32'd1000, 32'd1001, 32'd5000, 32'd0};
    table_pw[8] = $urandom;
    k = $urandom_range(0, 9);
    if (k == 9) run_pri(1'b0, 0, 32'd0, $urandom_range(0, 1) == 1);
    else        run_pri(1'b1, $urandom_range(0, 7), table_pw[k], $urandom_range(0, 1) == 1);
  endtask

  initial begin
    repeat (3) tick;
    check("rst_dc", 32'(dc_block_en_o), 0);
    check("rst_start", 32'(goertzel_start_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_locked", 32'(locked_o), 0);
    check("rst_gain", 32'({hga_en_o, pga_gain_o}), 0);
    rst = 1'b1;
    repeat (3) tick;
    check("idle_dc", 32'(dc_block_en_o), 0);
    check("idle_start", 32'(goertzel_start_o), 0);

    en_i = 1'b1;
    tick;
    m_gain = 0; m_locked = 0; m_pend = 0;

    repeat (3) run_pri(1'b1, $urandom_range(0, 7), 32'd50, 1'b0);
`ifndef AGC_HYSTERESIS_EN
    check("up3_pga", 32'(pga_gain_o), 3);
    check("up3_hga", 32'(hga_en_o), 0);
    repeat (13) run_pri(1'b1, $urandom_range(0, 7), 32'd50, 1'b0);
    check("sat_hi_gain", 32'({hga_en_o, pga_gain_o}), 15);
    check("sat_hi_locked", 32'(locked_o), 0);
    repeat (7) run_pri(1'b1, $urandom_range(0, 7), 32'd5000, 1'b0);
    check("at8_hga", 32'(hga_en_o), 1);
    check("at8_pga", 32'(pga_gain_o), 0);
    run_pri(1'b1, $urandom_range(0, 7), 32'd5000, 1'b0);
    check("cross_hga", 32'(hga_en_o), 0);
    check("cross_pga", 32'(pga_gain_o), 7);
    repeat (8) run_pri(1'b1, $urandom_range(0, 7), 32'd5000, 1'b0);
    check("sat_lo_gain", 32'({hga_en_o, pga_gain_o}), 0);
`endif
    run_pri(1'b1, $urandom_range(0, 7), 32'd100, 1'b0);
    check("edge_lo_locked", 32'(locked_o), 1);
    run_pri(1'b1, $urandom_range(0, 7), 32'd1000, 1'b0);
    check("edge_hi_locked", 32'(locked_o), 1);
    run_pri(1'b0, 0, 32'd0, 1'b1);
    check("timeout_locked", 32'(locked_o), 0);

    repeat (24) rand_pri;
    repeat (4) run_pri(1'b1, $urandom_range(0, 7), 32'd50, 1'b0);

    // drop enable while in WAIT (offset 7)
    for (int o = 0; o < 8; o++) begin
      check("drop_pre_start", 32'(goertzel_start_o), (o == 5) ? 1 : 0);
      if (o == 7) en_i = 1'b0;
      tick;
    end
    m_locked = 0;
    m_pend   = 0;
    for (int i = 0; i < 3; i++) begin
      check("drop_dc", 32'(dc_block_en_o), 0);
      check("drop_start", 32'(goertzel_start_o), 0);
      check("drop_timeout", 32'(timeout_o), 0);
      check_pins("drop");
      tick;
    end
    en_i = 1'b1;
    tick;
    m_gain = 0;

`ifdef AGC_HYSTERESIS_EN
    run_pri(1'b1, 3, 32'd50, 1'b0);
    run_pri(1'b1, 3, 32'd500, 1'b0);
    run_pri(1'b1, 3, 32'd50, 1'b0);
    check("hyst_no_step", 32'({hga_en_o, pga_gain_o}), 0);
    run_pri(1'b1, 3, 32'd50, 1'b0);
    check("hyst_step", 32'({hga_en_o, pga_gain_o}), 1);
`endif
    repeat (12) rand_pri;

    repeat (6) tick;
    #2 rst = 1'b0;
    #1;
    check("arst_dc", 32'(dc_block_en_o), 0);
    check("arst_locked", 32'(locked_o), 0);
    check("arst_gain", 32'({hga_en_o, pga_gain_o}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
